// File: rtl/riscv_ternlog_arbiter.sv
// Round-robin arbiter sharing one pipelined TERNLOG unit between two issue slots.
// Each result bit is imm8[{a,b,c}]; ops carry rd and slot id down a LATENCY-deep pipe.
module riscv_ternlog_arbiter #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_accept_o,
  input  logic [63:0]      req_a_i,
  input  logic [63:0]      req_b_i,
  input  logic [63:0]      req_c_i,
  input  logic [15:0]      req_imm8_i,
  input  logic [9:0]       req_rd_i,
  input  logic             stall_i,
  input  logic [1:0]       flush_i,
  output logic             resp_valid_o,
  output logic             resp_id_o,
  output logic [4:0]       resp_rd_o,
  output logic [31:0]      resp_result_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        ptr_q, ptr_d;

  logic [31:0] sel_a, sel_b, sel_c, lut;
  logic [7:0]  sel_imm;
  logic [4:0]  sel_rd;

  logic [LATENCY-1:0]       vld_q, vld_d;
  logic [LATENCY-1:0]       id_q, id_d;
  logic [LATENCY-1:0][4:0]  rd_q, rd_d;
  logic [LATENCY-1:0][31:0] res_q, res_d;
  logic [LATENCY-1:0]       kill;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    elig  = req_valid_i & ~flush_i & {2{~stall_i}};
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    // After any grant the other slot gets priority on the next conflict.
    ptr_d = ptr_q;
    if (|grant) ptr_d = grant[0];
  end

  always_comb begin
    sel_a   = grant[1] ? req_a_i[63:32]    : req_a_i[31:0];
    sel_b   = grant[1] ? req_b_i[63:32]    : req_b_i[31:0];
    sel_c   = grant[1] ? req_c_i[63:32]    : req_c_i[31:0];
    sel_imm = grant[1] ? req_imm8_i[15:8]  : req_imm8_i[7:0];
    sel_rd  = grant[1] ? req_rd_i[9:5]     : req_rd_i[4:0];
    lut     = '0;
    for (int i = 0; i < 32; i++) begin
      lut[i] = sel_imm[{sel_a[i], sel_b[i], sel_c[i]}];
    end
  end

  always_comb begin
    kill = '0;
    for (int k = 0; k < LATENCY; k++) begin
      kill[k] = id_q[k] ? flush_i[1] : flush_i[0];
    end
  end

  // Flush wins over stall: a held stage still loses its valid if its slot is flushed.
  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    rd_d  = rd_q;
    res_d = res_q;
    if (stall_i) begin
      vld_d = vld_q & ~kill;
    end else begin
      vld_d[0] = |grant;
      id_d[0]  = grant[1];
      rd_d[0]  = sel_rd;
      res_d[0] = lut;
      for (int k = 1; k < LATENCY; k++) begin
        vld_d[k] = vld_q[k-1] & ~kill[k-1];
        id_d[k]  = id_q[k-1];
        rd_d[k]  = rd_q[k-1];
        res_d[k] = res_q[k-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((&req_valid_i) && !stall_i && !(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
      vld_q <= '0;
      id_q  <= '0;
      rd_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      id_q  <= id_d;
      rd_q  <= rd_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  assign req_accept_o   = grant;
  assign resp_valid_o   = vld_q[LATENCY-1];
  assign resp_id_o      = id_q[LATENCY-1];
  assign resp_rd_o      = rd_q[LATENCY-1];
  assign resp_result_o  = res_q[LATENCY-1];
  assign busy_o         = |vld_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_riscv_ternlog_arbiter.sv
// Directed bench for riscv_ternlog_arbiter: LUT function, round-robin, stall, flush,
// reset mid-flight and counter saturation (second instance with CNT_W=4).
module tb_riscv_ternlog_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [63:0] req_a_i, req_b_i, req_c_i;
  logic [15:0] req_imm8_i;
  logic [9:0]  req_rd_i;
  logic        stall_i;
  logic [1:0]  flush_i;

  logic [1:0]  req_accept_o;
  logic        resp_valid_o, resp_id_o, busy_o;
  logic [4:0]  resp_rd_o;
  logic [31:0] resp_result_o;
  logic [15:0] conflict_cnt_o;

  logic [1:0]  s_accept;
  logic        s_valid, s_id, s_busy;
  logic [4:0]  s_rd;
  logic [31:0] s_result;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  riscv_ternlog_arbiter #(.LATENCY(2), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_accept_o(req_accept_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i), .req_imm8_i(req_imm8_i),
    .req_rd_i(req_rd_i), .stall_i(stall_i), .flush_i(flush_i), .resp_valid_o(resp_valid_o),
    .resp_id_o(resp_id_o), .resp_rd_o(resp_rd_o), .resp_result_o(resp_result_o),
    .busy_o(busy_o), .conflict_cnt_o(conflict_cnt_o)
  );

  riscv_ternlog_arbiter #(.LATENCY(2), .CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_accept_o(s_accept),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i), .req_imm8_i(req_imm8_i),
    .req_rd_i(req_rd_i), .stall_i(stall_i), .flush_i(flush_i), .resp_valid_o(s_valid),
    .resp_id_o(s_id), .resp_rd_o(s_rd), .resp_result_o(s_result),
    .busy_o(s_busy), .conflict_cnt_o(s_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_slot(input int s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [7:0] imm, input logic [4:0] rd);
    if (s == 0) begin
      req_a_i[31:0] = a; req_b_i[31:0] = b; req_c_i[31:0] = c;
      req_imm8_i[7:0] = imm; req_rd_i[4:0] = rd;
    end else begin
      req_a_i[63:32] = a; req_b_i[63:32] = b; req_c_i[63:32] = c;
      req_imm8_i[15:8] = imm; req_rd_i[9:5] = rd;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_valid_i = 2'b00; stall_i = 1'b0; flush_i = 2'b00;
    req_a_i = '0; req_b_i = '0; req_c_i = '0; req_imm8_i = '0; req_rd_i = '0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", resp_valid_o); end
    checks++; if (resp_id_o !== 1'b0) begin errors++; $display("FAIL reset_id: got %b exp 0", resp_id_o); end
    checks++; if (resp_rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd: got %h exp 0", resp_rd_o); end
    checks++; if (resp_result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", resp_result_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    checks++; if (conflict_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h exp 0", conflict_cnt_o); end
  endtask

  task automatic test_lut();
    logic [7:0]  imms [4] = '{8'hF0, 8'hCC, 8'hAA, 8'h96};
    logic [31:0] exps [4] = '{32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 32'hF00F0FF0};
    for (int j = 0; j < 4; j++) begin
      set_slot(0, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, imms[j], 5'(j + 3));
      req_valid_i = 2'b01;
      #1;
      checks++; if (req_accept_o !== 2'b01) begin errors++; $display("FAIL lut_accept[%0d]: got %b exp 01", j, req_accept_o); end
      tick();
      req_valid_i = 2'b00;
      checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL lut_early[%0d]: got %b exp 0", j, resp_valid_o); end
      tick();
      checks++; if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL lut_valid[%0d]: got %b exp 1", j, resp_valid_o); end
      checks++; if (resp_result_o !== exps[j]) begin errors++; $display("FAIL lut_result[%0d]: got %h exp %h", j, resp_result_o, exps[j]); end
      checks++; if (resp_rd_o !== 5'(j + 3) || resp_id_o !== 1'b0) begin errors++; $display("FAIL lut_tag[%0d]: got rd %0d id %b exp rd %0d id 0", j, resp_rd_o, resp_id_o, j + 3); end
      tick();
      checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL lut_pulse[%0d]: got %b exp 0", j, resp_valid_o); end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_acc;
    logic       exp_id;
    do_reset();
    set_slot(0, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 8'hF0, 5'd1);
    set_slot(1, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 8'hCC, 5'd2);
    for (int t = 0; t < 6; t++) begin
      if (t < 4) begin
        req_valid_i = 2'b11;
        exp_acc = (t % 2 == 0) ? 2'b01 : 2'b10;
        #1;
        checks++; if (req_accept_o !== exp_acc) begin errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", t, req_accept_o, exp_acc); end
      end else begin
        req_valid_i = 2'b00;
      end
      tick();
      if (t >= 1 && t <= 4) begin
        exp_id = ((t - 1) % 2 == 1);
        checks++; if (resp_valid_o !== 1'b1 || resp_id_o !== exp_id) begin errors++; $display("FAIL rr_resp[%0d]: got v %b id %b exp v 1 id %b", t, resp_valid_o, resp_id_o, exp_id); end
        checks++; if (resp_result_o !== (exp_id ? 32'hFF00FF00 : 32'hFFFF0000) || resp_rd_o !== (exp_id ? 5'd2 : 5'd1)) begin errors++; $display("FAIL rr_data[%0d]: got %h rd %0d", t, resp_result_o, resp_rd_o); end
      end
    end
    checks++; if (conflict_cnt_o !== 16'd4) begin errors++; $display("FAIL rr_conflicts: got %0d exp 4", conflict_cnt_o); end
  endtask

  task automatic test_stall();
    int pulses;
    logic [31:0] got_res;
    logic [4:0]  got_rd;
    logic        got_id;
    set_slot(1, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 8'hFE, 5'd10);
    req_valid_i = 2'b10;
    #1;
    checks++; if (req_accept_o !== 2'b10) begin errors++; $display("FAIL stall_accept: got %b exp 10", req_accept_o); end
    tick();
    stall_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      checks++; if (req_accept_o !== 2'b00) begin errors++; $display("FAIL stall_noaccept[%0d]: got %b exp 00", t, req_accept_o); end
      tick();
      checks++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got v %b busy %b exp v 0 busy 1", t, resp_valid_o, busy_o); end
    end
    stall_i = 1'b0; req_valid_i = 2'b00;
    pulses = 0; got_res = '0; got_rd = '0; got_id = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (resp_valid_o === 1'b1) begin
        pulses++; got_res = resp_result_o; got_rd = resp_rd_o; got_id = resp_id_o;
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL stall_pulses: got %0d exp 1", pulses); end
    checks++; if (got_res !== 32'hAAAAAAAA || got_rd !== 5'd10 || got_id !== 1'b1) begin errors++; $display("FAIL stall_resp: got %h rd %0d id %b exp AAAAAAAA rd 10 id 1", got_res, got_rd, got_id); end
    // stall with the op sitting in the output stage: response must stay put
    req_valid_i = 2'b10;
    tick();
    req_valid_i = 2'b00;
    tick();
    stall_i = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick();
      checks++; if (resp_valid_o !== 1'b1 || resp_result_o !== 32'hAAAAAAAA) begin errors++; $display("FAIL stall_outhold[%0d]: got v %b %h exp v 1 AAAAAAAA", t, resp_valid_o, resp_result_o); end
    end
    stall_i = 1'b0;
    tick();
    checks++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL stall_drain: got v %b busy %b exp 0 0", resp_valid_o, busy_o); end
  endtask

  task automatic test_flush();
    set_slot(0, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 8'hF0, 5'd3);
    set_slot(1, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 8'hCC, 5'd4);
    req_valid_i = 2'b01;
    #1;
    checks++; if (req_accept_o !== 2'b01) begin errors++; $display("FAIL flush_acc0: got %b exp 01", req_accept_o); end
    tick();
    req_valid_i = 2'b11; flush_i = 2'b01;
    #1;
    checks++; if (req_accept_o !== 2'b10) begin errors++; $display("FAIL flush_acc1: got %b exp 10", req_accept_o); end
    tick();
    req_valid_i = 2'b00; flush_i = 2'b00;
    checks++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL flush_killed: got v %b busy %b exp v 0 busy 1", resp_valid_o, busy_o); end
    tick();
    checks++; if (resp_valid_o !== 1'b1 || resp_id_o !== 1'b1 || resp_rd_o !== 5'd4 || resp_result_o !== 32'hFF00FF00) begin errors++; $display("FAIL flush_survivor: got v %b id %b rd %0d %h exp v 1 id 1 rd 4 FF00FF00", resp_valid_o, resp_id_o, resp_rd_o, resp_result_o); end
    tick();
    checks++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_idle: got v %b busy %b exp 0 0", resp_valid_o, busy_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid_i = 2'b11;
    tick(); tick(); tick();
    req_valid_i = 2'b00;
    rst_i = 1'b1;
    tick();
    checks++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || resp_result_o !== 32'd0 || resp_rd_o !== 5'd0 || resp_id_o !== 1'b0) begin errors++; $display("FAIL rstmid_out: got v %b busy %b %h rd %0d id %b exp all 0", resp_valid_o, busy_o, resp_result_o, resp_rd_o, resp_id_o); end
    checks++; if (conflict_cnt_o !== 16'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d exp 0", conflict_cnt_o); end
    rst_i = 1'b0;
    tick();
    checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_noresp: got %b exp 0", resp_valid_o); end
    req_valid_i = 2'b11;
    #1;
    checks++; if (req_accept_o !== 2'b01) begin errors++; $display("FAIL rstmid_ptr: got %b exp 01", req_accept_o); end
    tick();
    req_valid_i = 2'b00;
    tick(); tick();
  endtask

  task automatic test_saturate();
    do_reset();
    req_valid_i = 2'b11;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (t == 14) begin
        checks++; if (s_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach: got %h exp F", s_cnt); end
      end
    end
    req_valid_i = 2'b00;
    checks++; if (s_cnt !== 4'hF) begin errors++; $display("FAIL sat_nowrap: got %h exp F", s_cnt); end
    checks++; if (conflict_cnt_o !== 16'd20) begin errors++; $display("FAIL sat_wide: got %0d exp 20", conflict_cnt_o); end
    stall_i = 1'b1; req_valid_i = 2'b11;
    tick();
    stall_i = 1'b0; req_valid_i = 2'b00;
    checks++; if (conflict_cnt_o !== 16'd20) begin errors++; $display("FAIL sat_stall: got %0d exp 20", conflict_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_lut();
    test_round_robin();
    test_stall();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
